// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - AXI4 responder backed by a behavioural single-port SRAM
//
// Serves one AXI4 transaction at a time. A pending write always wins over a
// pending read. FIXED and INCR bursts up to 256 beats, byte strobes, ID echo
// and a programmable read latency are supported.
//
// Ports:
//   clk, rst                         clock; asynchronous active-high reset
//   aw*  (valid/ready/addr/id/len/size/burst)   write-address channel
//   w*   (valid/ready/data/strb/last)           write-data channel
//   b*   (valid/ready/resp/id)                  write-response channel
//   ar*  (valid/ready/addr/id/len/size/burst)   read-address channel
//   r*   (valid/ready/data/resp/last/id)        read-data channel
//
// Parameters:
//   ADDR_W    word-index width; array holds 2**ADDR_W 32-bit words
//   READ_LAT  idle cycles between AR acceptance and the first R beat (0..15)

module axi4_sram_slave #(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  // write address
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  // write data
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  // write response
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  // read address
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // read data
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  typedef enum logic [2:0] {
    IDLE,
    W_DATA,
    W_RESP,
    R_WAIT,
    R_DATA
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] LAT         = 4'(READ_LAT);

  state_t      state;
  state_t      state_nxt;

  // Latched transaction context, shared by the read and write paths since
  // only one transaction is ever in flight.
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [7:0]  beat_q;
  logic [3:0]  lat_q;
  logic        err_q;

  logic [31:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       addr_nxt;
  logic              burst_ok;
  logic              last_beat;

  // Upper address bits are ignored, so the array aliases across the 4 GB map.
  assign word_idx  = addr_q[ADDR_W+1:2];
  assign burst_ok  = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR);
  // Anything that is not FIXED advances like INCR; narrow sizes only change
  // the step, the data path is always a full word.
  assign addr_nxt  = (burst_q == BURST_FIXED) ? addr_q : addr_q + (32'd1 << size_q);
  assign last_beat = (beat_q == len_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and channel outputs. Ready signals are held low while reset
  // is asserted so nothing is accepted during reset.
  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = RESP_OKAY;
    rvalid    = 1'b0;
    rresp     = RESP_OKAY;
    rlast     = 1'b0;
    bid       = id_q;
    rid       = id_q;
    rdata     = mem[word_idx];

    case (state)
      IDLE: begin
        awready = ~rst;
        arready = ~rst & ~awvalid;
        if (awvalid) begin
          state_nxt = W_DATA;
        end else if (arvalid) begin
          state_nxt = (LAT == 4'd0) ? R_DATA : R_WAIT;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        // Burst length comes from awlen; wlast is only checked, never used
        // to terminate.
        if (wvalid && last_beat) begin
          state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) begin
          state_nxt = IDLE;
        end
      end
      R_WAIT: begin
        if (lat_q == 4'd1) begin
          state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = last_beat;
        rresp  = burst_ok ? RESP_OKAY : RESP_SLVERR;
        if (rready && last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Transaction context and beat/latency counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid) begin
            id_q    <= awid;
            addr_q  <= awaddr;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= awburst;
            beat_q  <= '0;
            err_q   <= 1'b0;
          end else if (arvalid) begin
            id_q    <= arid;
            addr_q  <= araddr;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            beat_q  <= '0;
            lat_q   <= LAT;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            addr_q <= addr_nxt;
            beat_q <= beat_q + 8'd1;
            if (!burst_ok || (wlast != last_beat)) begin
              err_q <= 1'b1;
            end
          end
        end
        R_WAIT: begin
          lat_q <= lat_q - 4'd1;
        end
        R_DATA: begin
          if (rready) begin
            addr_q <= addr_nxt;
            beat_q <= beat_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Storage array: not reset, byte-lane write enables from wstrb.
  always_ff @(posedge clk) begin
    if ((state == W_DATA) && wvalid) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - randomized self-checking bench for axi4_sram_slave

module tb_axi4_sram_slave;

  localparam int ADDR_W   = 16;
  localparam int READ_LAT = 1;

  logic        clk;
  logic        rst;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  axi4_sram_slave #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word store keyed by decoded word index.
  logic [31:0] model_mem [int unsigned];

  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] rbuf [256];
  logic        rlast_buf [256];
  logic [3:0]  rid_buf [256];
  logic [1:0]  rresp_buf [256];
  int          stall_bad;
  int          rd_lat;
  logic        rvalid_after;
  logic [1:0]  b_resp_got;
  logic [3:0]  b_id_got;
  int          b_drop;
  logic        b_after;

  function automatic int unsigned widx(input logic [31:0] a);
    return 32'(a[ADDR_W+1:2]);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int unsigned k,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return a;
    return a + k * (32'd1 << size);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    for (int k = 0; k <= int'(len); k++) begin
      int unsigned idx;
      logic [31:0] w;
      idx = widx(beat_addr(a, k, size, burst));
      w   = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (sbuf[k][i]) w[8*i +: 8] = wbuf[k][8*i +: 8];
      model_mem[idx] = w;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input int unsigned k,
                                             input logic [2:0] size, input logic [1:0] burst);
    int unsigned idx;
    idx = widx(beat_addr(a, k, size, burst));
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst;
    #1;
    while (!awready && n < 100) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (n >= 100) begin n_fail++; $display("FAIL aw_timeout waited=%0d limit=100", n); end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] len, input bit bad_last);
    for (int k = 0; k <= int'(len); k++) begin
      int n = 0;
      wvalid = 1'b1; wdata = wbuf[k]; wstrb = sbuf[k];
      wlast  = bad_last ? (k == 0) : (k == int'(len));
      #1;
      while (!wready && n < 100) begin @(negedge clk); #1; n++; end
      n_checks++;
      if (n >= 100) begin n_fail++; $display("FAIL w_timeout beat=%0d waited=%0d limit=100", k, n); end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(input int hold);
    int n = 0;
    bready = 1'b0;
    b_drop = 0;
    #1;
    while (!bvalid && n < 100) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (n >= 100) begin n_fail++; $display("FAIL b_timeout waited=%0d limit=100", n); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      if (!bvalid) b_drop++;
    end
    bready = 1'b1;
    b_resp_got = bresp; b_id_got = bid;
    @(negedge clk);
    bready = 1'b0;
    #1;
    b_after = bvalid;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    arvalid = 1'b1; arid = id; araddr = a; arlen = len; arsize = size; arburst = burst;
    #1;
    while (!arready && n < 100) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (n >= 100) begin n_fail++; $display("FAIL ar_timeout waited=%0d limit=100", n); end
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Starts on the first negedge after the AR handshake. mode: 0 always
  // ready, 1 toggle starting at 1, 2 random.
  task automatic collect_r(input logic [7:0] len, input int mode);
    int k = 0;
    int g = 0;
    bit tog = 1'b1;
    logic rr, c_valid, c_last;
    logic [31:0] c_data;
    logic [3:0] c_id;
    logic [1:0] c_resp;
    stall_bad = 0;
    #1;
    rd_lat = 1;
    while (!rvalid && g < 100) begin @(negedge clk); #1; rd_lat++; g++; end
    while (k <= int'(len) && g < 3000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      rready = rr;
      c_valid = rvalid; c_data = rdata; c_last = rlast; c_id = rid; c_resp = rresp;
      @(negedge clk); #1; g++;
      if (c_valid && rr) begin
        rbuf[k] = c_data; rlast_buf[k] = c_last; rid_buf[k] = c_id; rresp_buf[k] = c_resp;
        k++;
      end else if (c_valid && (!rvalid || rdata !== c_data || rlast !== c_last ||
                               rid !== c_id || rresp !== c_resp)) begin
        stall_bad++;
      end
    end
    rready = 1'b0;
    rvalid_after = rvalid;
    n_checks++;
    if (g >= 3000) begin n_fail++; $display("FAIL r_timeout beats=%0d need=%0d", k, int'(len) + 1); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=000000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    n_checks++;
    if ({bresp, rresp, bid, rid} !== 12'h0) begin
      n_fail++; $display("FAIL reset_resp_id got=%h exp=000", {bresp, rresp, bid, rid});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({awready, arready} !== 2'b11) begin
      n_fail++; $display("FAIL idle_ready got=%b exp=11", {awready, arready});
    end
  endtask

  task automatic test_init_long_burst;
    for (int k = 0; k < 256; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
    send_aw(4'h1, 32'h8000_0000, 8'd255, 3'd2, 2'b01);
    send_w(8'd255, 1'b0);
    get_b(0);
    model_write(32'h8000_0000, 8'd255, 3'd2, 2'b01);
    n_checks++;
    if (b_resp_got !== 2'b00) begin n_fail++; $display("FAIL long_bresp got=%b exp=00", b_resp_got); end
    send_ar(4'h2, 32'h8000_0000, 8'd255, 3'd2, 2'b01);
    collect_r(8'd255, 2);
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (rbuf[k] !== model_read(32'h8000_0000, k, 3'd2, 2'b01) || rlast_buf[k] !== (k == 255)) begin
        n_fail++;
        $display("FAIL long_beat%0d got=%h/%b exp=%h/%b", k, rbuf[k], rlast_buf[k],
                 model_read(32'h8000_0000, k, 3'd2, 2'b01), (k == 255));
      end
    end
    n_checks++;
    if (rvalid_after !== 1'b0 || stall_bad != 0) begin
      n_fail++; $display("FAIL long_end rvalid=%b stalls_bad=%0d exp=0/0", rvalid_after, stall_bad);
    end
  endtask

  task automatic test_single;
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'hF;
    send_aw(4'd3, 32'h8000_0010, 8'd0, 3'd2, 2'b01);
    send_w(8'd0, 1'b0);
    get_b(0);
    model_write(32'h8000_0010, 8'd0, 3'd2, 2'b01);
    n_checks++;
    if (b_resp_got !== 2'b00 || b_id_got !== 4'd3) begin
      n_fail++; $display("FAIL single_b got=%b/%0d exp=00/3", b_resp_got, b_id_got);
    end
    send_ar(4'd5, 32'h8000_0010, 8'd0, 3'd2, 2'b01);
    collect_r(8'd0, 0);
    n_checks++;
    if (rd_lat != READ_LAT + 1) begin
      n_fail++; $display("FAIL single_latency got=%0d exp=%0d", rd_lat, READ_LAT + 1);
    end
    n_checks++;
    if (rbuf[0] !== 32'hDEAD_BEEF || rlast_buf[0] !== 1'b1 || rid_buf[0] !== 4'd5 || rresp_buf[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL single_r got=%h/%b/%0d/%b exp=deadbeef/1/5/00", rbuf[0], rlast_buf[0], rid_buf[0], rresp_buf[0]);
    end
  endtask

  task automatic test_strobes;
    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'hF;
    send_aw(4'd7, 32'h8000_0020, 8'd0, 3'd2, 2'b01); send_w(8'd0, 1'b0); get_b(0);
    model_write(32'h8000_0020, 8'd0, 3'd2, 2'b01);
    wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'h5;
    send_aw(4'd7, 32'h8000_0020, 8'd0, 3'd2, 2'b01); send_w(8'd0, 1'b0); get_b(0);
    model_write(32'h8000_0020, 8'd0, 3'd2, 2'b01);
    send_ar(4'd8, 32'h8000_0020, 8'd0, 3'd2, 2'b01);
    collect_r(8'd0, 0);
    n_checks++;
    if (rbuf[0] !== 32'h11BB_33DD) begin
      n_fail++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rbuf[0]);
    end
  endtask

  task automatic test_backpressure_fixed;
    for (int k = 0; k < 4; k++) begin wbuf[k] = k + 1; sbuf[k] = 4'hF; end
    send_aw(4'd2, 32'h8000_0100, 8'd3, 3'd2, 2'b01); send_w(8'd3, 1'b0); get_b(0);
    model_write(32'h8000_0100, 8'd3, 3'd2, 2'b01);
    send_ar(4'd4, 32'h8000_0100, 8'd3, 3'd2, 2'b01);
    collect_r(8'd3, 1);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rbuf[k] !== 32'(k + 1) || rlast_buf[k] !== (k == 3)) begin
        n_fail++; $display("FAIL incr_bp_beat%0d got=%h/%b exp=%h/%b", k, rbuf[k], rlast_buf[k], k + 1, (k == 3));
      end
    end
    n_checks++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL incr_bp_stable got=%0d exp=0", stall_bad); end
    send_ar(4'd6, 32'h8000_0100, 8'd2, 3'd2, 2'b00);
    collect_r(8'd2, 0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rbuf[k] !== 32'd1 || rlast_buf[k] !== (k == 2)) begin
        n_fail++; $display("FAIL fixed_beat%0d got=%h/%b exp=1/%b", k, rbuf[k], rlast_buf[k], (k == 2));
      end
    end
  endtask

  task automatic test_simultaneous;
    wbuf[0] = $urandom; sbuf[0] = 4'hF;
    @(negedge clk);
    awvalid = 1; awid = 4'd6; awaddr = 32'h8000_0040; awlen = 0; awsize = 2; awburst = 2'b01;
    arvalid = 1; arid = 4'd9; araddr = 32'h8000_0040; arlen = 0; arsize = 2; arburst = 2'b01;
    #1;
    n_checks++;
    if ({awready, arready} !== 2'b10) begin
      n_fail++; $display("FAIL simul_ready got=%b exp=10", {awready, arready});
    end
    @(negedge clk);
    awvalid = 0;
    #1;
    n_checks++;
    if (arready !== 1'b0) begin n_fail++; $display("FAIL simul_ar_blocked_w got=%b exp=0", arready); end
    send_w(8'd0, 1'b0);
    #1;
    n_checks++;
    if (arready !== 1'b0) begin n_fail++; $display("FAIL simul_ar_blocked_b got=%b exp=0", arready); end
    get_b(0);
    model_write(32'h8000_0040, 8'd0, 3'd2, 2'b01);
    n_checks++;
    if (arready !== 1'b1 || b_id_got !== 4'd6) begin
      n_fail++; $display("FAIL simul_after_b arready=%b bid=%0d exp=1/6", arready, b_id_got);
    end
    @(negedge clk);
    arvalid = 0;
    collect_r(8'd0, 0);
    n_checks++;
    if (rbuf[0] !== model_read(32'h8000_0040, 0, 3'd2, 2'b01) || rid_buf[0] !== 4'd9) begin
      n_fail++;
      $display("FAIL simul_read got=%h/%0d exp=%h/9", rbuf[0], rid_buf[0], model_read(32'h8000_0040, 0, 3'd2, 2'b01));
    end
  endtask

  task automatic test_protocol_errors;
    wbuf[0] = $urandom; sbuf[0] = 4'hF;
    send_aw(4'd1, 32'h8000_0060, 8'd0, 3'd2, 2'b11); send_w(8'd0, 1'b0); get_b(0);
    model_write(32'h8000_0060, 8'd0, 3'd2, 2'b11);
    n_checks++;
    if (b_resp_got !== 2'b10) begin n_fail++; $display("FAIL bad_burst_bresp got=%b exp=10", b_resp_got); end
    send_ar(4'd1, 32'h8000_0060, 8'd0, 3'd2, 2'b11);
    collect_r(8'd0, 0);
    n_checks++;
    if (rresp_buf[0] !== 2'b10 || rbuf[0] !== model_read(32'h8000_0060, 0, 3'd2, 2'b11)) begin
      n_fail++; $display("FAIL bad_burst_r got=%b/%h exp=10/%h", rresp_buf[0], rbuf[0],
                         model_read(32'h8000_0060, 0, 3'd2, 2'b11));
    end
    wbuf[0] = $urandom; wbuf[1] = $urandom; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    send_aw(4'hC, 32'h8000_0070, 8'd1, 3'd2, 2'b01); send_w(8'd1, 1'b1); get_b(5);
    model_write(32'h8000_0070, 8'd1, 3'd2, 2'b01);
    n_checks++;
    if (b_resp_got !== 2'b10 || b_id_got !== 4'hC) begin
      n_fail++; $display("FAIL wlast_err_b got=%b/%0d exp=10/12", b_resp_got, b_id_got);
    end
    n_checks++;
    if (b_drop != 0 || b_after !== 1'b0) begin
      n_fail++; $display("FAIL bvalid_hold drops=%0d after=%b exp=0/0", b_drop, b_after);
    end
    send_ar(4'd3, 32'h8000_0070, 8'd1, 3'd2, 2'b01);
    collect_r(8'd1, 0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (rbuf[k] !== wbuf[k]) begin
        n_fail++; $display("FAIL wlast_err_data%0d got=%h exp=%h", k, rbuf[k], wbuf[k]);
      end
    end
  endtask

  task automatic test_wrap;
    wbuf[0] = $urandom; wbuf[1] = $urandom; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    send_aw(4'd2, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01); send_w(8'd1, 1'b0); get_b(0);
    model_write(32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
    send_ar(4'd2, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
    collect_r(8'd1, 0);
    n_checks++;
    if (rbuf[1] !== wbuf[1] || rbuf[0] !== wbuf[0]) begin
      n_fail++; $display("FAIL addr_wrap got=%h,%h exp=%h,%h", rbuf[0], rbuf[1], wbuf[0], wbuf[1]);
    end
    send_ar(4'd2, 32'h8000_0000, 8'd0, 3'd2, 2'b01);
    collect_r(8'd0, 0);
    n_checks++;
    if (rbuf[0] !== wbuf[1]) begin
      n_fail++; $display("FAIL index_alias got=%h exp=%h", rbuf[0], wbuf[1]);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      logic [3:0]  id;
      logic [31:0] a;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      id = 4'($urandom); a = 32'h8000_0000 | ($urandom & 32'h2FF);
      len = 8'($urandom_range(0, 15)); size = 3'($urandom_range(0, 2)); burst = 2'($urandom_range(0, 1));
      for (int k = 0; k <= int'(len); k++) begin wbuf[k] = $urandom; sbuf[k] = 4'($urandom); end
      send_aw(id, a, len, size, burst); send_w(len, 1'b0); get_b(0);
      model_write(a, len, size, burst);
      n_checks++;
      if (b_resp_got !== 2'b00 || b_id_got !== id) begin
        n_fail++; $display("FAIL rand%0d_b got=%b/%0d exp=00/%0d", it, b_resp_got, b_id_got, id);
      end
      send_ar(~id, a, len, size, burst);
      collect_r(len, 2);
      for (int k = 0; k <= int'(len); k++) begin
        n_checks++;
        if (rbuf[k] !== model_read(a, k, size, burst) || rlast_buf[k] !== (k == int'(len)) ||
            rid_buf[k] !== ~id || rresp_buf[k] !== 2'b00) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d got=%h/%b/%0d/%b exp=%h/%b/%0d/00", it, k, rbuf[k], rlast_buf[k],
                   rid_buf[k], rresp_buf[k], model_read(a, k, size, burst), (k == int'(len)), ~id);
        end
      end
      n_checks++;
      if (stall_bad != 0 || rd_lat != READ_LAT + 1) begin
        n_fail++; $display("FAIL rand%0d_timing stalls_bad=%0d lat=%0d exp=0/%0d", it, stall_bad, rd_lat, READ_LAT + 1);
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int n = 0;
    send_ar(4'd10, 32'h8000_0000, 8'd7, 3'd2, 2'b01);
    #1;
    while (!rvalid && n < 100) begin @(negedge clk); #1; n++; end
    rready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (rvalid !== 1'b1 || rlast !== 1'b0) begin
      n_fail++; $display("FAIL mid_read_beat2 rvalid=%b rlast=%b exp=1/0", rvalid, rlast);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rvalid, rlast, bvalid} !== 3'b000 || rid !== 4'd0) begin
      n_fail++; $display("FAIL mid_read_reset rvalid/rlast/bvalid=%b rid=%0d exp=000/0", {rvalid, rlast, bvalid}, rid);
    end
    rready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({awready, arready, rvalid} !== 3'b110) begin
      n_fail++; $display("FAIL mid_read_idle got=%b exp=110", {awready, arready, rvalid});
    end
    send_ar(4'd13, 32'h8000_0100, 8'd0, 3'd2, 2'b01);
    collect_r(8'd0, 0);
    n_checks++;
    if (rbuf[0] !== model_read(32'h8000_0100, 0, 3'd2, 2'b01) || rid_buf[0] !== 4'd13 || rlast_buf[0] !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_read got=%h/%0d/%b exp=%h/13/1", rbuf[0], rid_buf[0], rlast_buf[0],
                         model_read(32'h8000_0100, 0, 3'd2, 2'b01));
    end
  endtask

  initial begin
    test_reset();
    test_init_long_burst();
    test_single();
    test_strobes();
    test_backpressure_fixed();
    test_simultaneous();
    test_protocol_errors();
    test_wrap();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
